// File: rtl/vga_console_writer_pkg.sv
// ============================================================================
// Module  : vga_console_writer_pkg
// Brief   : Shared constants for the VGA text console writer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package vga_console_writer_pkg;

    localparam int C_DEF_COLS = 70;
    localparam int C_DEF_ROWS = 30;

    localparam logic [1:0] C_ST_IDLE       = 2'd0;
    localparam logic [1:0] C_ST_SCROLL_CLR = 2'd1;
    localparam logic [1:0] C_ST_FULL_CLR   = 2'd2;

    localparam logic [7:0] C_CH_BS    = 8'h08;
    localparam logic [7:0] C_CH_LF    = 8'h0A;
    localparam logic [7:0] C_CH_CR    = 8'h0D;
    localparam logic [7:0] C_CH_SP    = 8'h20;
    localparam logic [7:0] C_CH_TILDE = 8'h7E;

endpackage

`default_nettype wire

// File: rtl/vga_console_writer_addr_gen.sv
// ============================================================================
// Module  : console_addr_gen
// Brief   : Maps a logical (row, col) plus scroll offset to a memory address.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module console_addr_gen
    import vga_console_writer_pkg::*;
#(
    parameter int COLS = C_DEF_COLS,
    parameter int ROWS = C_DEF_ROWS
) (
    input  logic [4:0]  top_row,
    input  logic [4:0]  row,
    input  logic [6:0]  col,
    output logic [11:0] addr
);

    localparam logic [5:0]  C_ROWS6  = 6'(ROWS);
    localparam logic [11:0] C_COLS12 = 12'(COLS);

    logic [5:0]  w_sum;
    logic [4:0]  w_phys_row;

    // Both operands are below ROWS, so a single conditional subtract is a full mod.
    always_comb begin
        w_sum      = {1'b0, top_row} + {1'b0, row};
        w_phys_row = (w_sum >= C_ROWS6) ? 5'(w_sum - C_ROWS6) : w_sum[4:0];
        addr       = ({7'd0, w_phys_row} * C_COLS12) + {5'd0, col};
    end

endmodule

`default_nettype wire

// File: rtl/vga_console_writer.sv
// ============================================================================
// Module  : vga_console_writer
// Brief   : Streams ASCII into a scrolling text-mode character memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module vga_console_writer
    import vga_console_writer_pkg::*;
#(
    parameter int COLS = C_DEF_COLS,
    parameter int ROWS = C_DEF_ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    input  logic        clear_req,
    output logic        vm_we,
    output logic [11:0] vm_waddr,
    output logic [7:0]  vm_wdata,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic [4:0]  top_row,
    output logic        busy
);

    localparam logic [6:0]  C_COL_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  C_ROW_LAST    = 5'(ROWS - 1);
    localparam logic [11:0] C_SCROLL_LAST = 12'(COLS - 1);
    localparam logic [11:0] C_CELL_LAST   = 12'(COLS * ROWS - 1);

    logic [1:0]  r_state, w_state_nxt;
    logic        r_we, w_we_nxt;
    logic [11:0] r_waddr, w_waddr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic [4:0]  r_row, w_row_nxt;
    logic [6:0]  r_col, w_col_nxt;
    logic [4:0]  r_top, w_top_nxt;
    logic [11:0] r_cnt, w_cnt_nxt;

    logic [6:0]  w_gen_col;
    logic [11:0] w_gen_addr;
    logic        w_printable;

    // During a scroll clear, cur_row is ROWS-1 and top_row has already advanced,
    // so the generator points at the freshly exposed physical row.
    always_comb begin
        if (r_state == C_ST_SCROLL_CLR)
            w_gen_col = r_cnt[6:0];
        else if (ch_data == C_CH_BS)
            w_gen_col = r_col - 7'd1;
        else
            w_gen_col = r_col;
    end

    console_addr_gen #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_addr_gen (
        .top_row (r_top),
        .row     (r_row),
        .col     (w_gen_col),
        .addr    (w_gen_addr)
    );

    assign w_printable = (ch_data >= C_CH_SP) && (ch_data <= C_CH_TILDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= C_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_top_nxt   = r_top;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            C_ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = C_ST_FULL_CLR;
                    w_cnt_nxt   = 12'd0;
                end else if (ch_valid) begin
                    logic do_nl;
                    do_nl = 1'b0;
                    if (w_printable) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = w_gen_addr;
                        w_wdata_nxt = ch_data;
                        if (r_col == C_COL_LAST)
                            do_nl = 1'b1;
                        else
                            w_col_nxt = r_col + 7'd1;
                    end else if ((ch_data == C_CH_LF) || (ch_data == C_CH_CR)) begin
                        do_nl = 1'b1;
                    end else if ((ch_data == C_CH_BS) && (r_col != 7'd0)) begin
                        w_col_nxt   = r_col - 7'd1;
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = w_gen_addr;
                        w_wdata_nxt = C_CH_SP;
                    end
                    if (do_nl) begin
                        w_col_nxt = 7'd0;
                        if (r_row != C_ROW_LAST) begin
                            w_row_nxt = r_row + 5'd1;
                        end else begin
                            w_top_nxt   = (r_top == C_ROW_LAST) ? 5'd0 : r_top + 5'd1;
                            w_state_nxt = C_ST_SCROLL_CLR;
                            w_cnt_nxt   = 12'd0;
                        end
                    end
                end
            end
            C_ST_SCROLL_CLR: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = w_gen_addr;
                w_wdata_nxt = C_CH_SP;
                if (r_cnt == C_SCROLL_LAST)
                    w_state_nxt = C_ST_IDLE;
                else
                    w_cnt_nxt = r_cnt + 12'd1;
            end
            C_ST_FULL_CLR: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_cnt;
                w_wdata_nxt = C_CH_SP;
                if (r_cnt == C_CELL_LAST) begin
                    w_state_nxt = C_ST_IDLE;
                    w_row_nxt   = 5'd0;
                    w_col_nxt   = 7'd0;
                    w_top_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 12'd1;
                end
            end
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    always_comb begin
        ch_ready = (r_state == C_ST_IDLE) && !clear_req && !rst;
        busy     = (r_state == C_ST_SCROLL_CLR) || (r_state == C_ST_FULL_CLR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= 12'd0;
            r_wdata <= 8'd0;
            r_row   <= 5'd0;
            r_col   <= 7'd0;
            r_top   <= 5'd0;
            r_cnt   <= 12'd0;
        end else begin
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_top   <= w_top_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign vm_we    = r_we;
    assign vm_waddr = r_waddr;
    assign vm_wdata = r_wdata;
    assign cur_row  = r_row;
    assign cur_col  = r_col;
    assign top_row  = r_top;

endmodule

`default_nettype wire

// File: doc/vga_console_writer.md
VGA_CONSOLE_WRITER -- requirements
Module: vga_console_writer

Interface
REQ-001 Parameter COLS, default 70: characters per text row.
REQ-002 Parameter ROWS, default 30: text rows on screen; COLS*ROWS SHALL be at most 4096.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ch_valid  input  1  an ASCII character is offered.
REQ-006 ch_data  input  8  the offered ASCII code.
REQ-007 ch_ready  output  1  writer accepts ch_data this cycle; a transfer occurs when ch_valid and ch_ready are both high.
REQ-008 clear_req  input  1  single-cycle request to blank the whole screen.
REQ-009 vm_we  output  1  character-memory write strobe.
REQ-010 vm_waddr  output  12  character-memory write address.
REQ-011 vm_wdata  output  8  character-memory write data (ASCII).
REQ-012 cur_row  output  5  logical cursor row, 0..ROWS-1.
REQ-013 cur_col  output  7  cursor column, 0..COLS-1.
REQ-014 top_row  output  5  physical memory row displayed at screen top; the display adds it modulo ROWS.
REQ-015 busy  output  1  a clear sequence is in progress.

Function
REQ-016 The state machine SHALL have the states IDLE, SCROLL_CLR and FULL_CLR.
REQ-017 ch_ready SHALL equal (state==IDLE) and not clear_req and not rst.
REQ-018 busy SHALL be high exactly when state is SCROLL_CLR or FULL_CLR.
REQ-019 vm_we, vm_waddr and vm_wdata SHALL be registered; a write caused by a transfer at edge k SHALL be visible during the cycle after edge k. vm_we is high for exactly one cycle per write.
REQ-020 The physical row SHALL be (top_row+cur_row) mod ROWS; the address SHALL be phys_row*COLS+col.
REQ-021 Printable characters (0x20..0x7E) SHALL be written at the cursor, and cur_col SHALL then increment. At col COLS-1, the write is followed by a newline.
REQ-022 On 0x0A or 0x0D, the writer SHALL perform a newline with no memory write.
REQ-023 On 0x08 with cur_col>0: cur_col SHALL decrement and 0x20 SHALL be written at the new position. With cur_col==0 the character is a no-op; the cursor never wraps to the previous row.
REQ-024 Any other code SHALL be consumed without effect.
REQ-025 Newline with cur_row<ROWS-1: cur_row increments and cur_col becomes 0.
REQ-026 Newline with cur_row==ROWS-1: top_row increments (ROWS-1 wraps to 0), cur_row holds, cur_col becomes 0, and the state becomes SCROLL_CLR.
REQ-027 SCROLL_CLR SHALL write 0x20 to the COLS cells of the newly exposed physical row, one per cycle, in ascending address order, then return to IDLE.
REQ-028 In IDLE with clear_req high, the state SHALL go to FULL_CLR.
REQ-029 FULL_CLR SHALL write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, in ascending order. It SHALL then set cur_row, cur_col and top_row to 0 and return to IDLE.
REQ-030 clear_req SHALL be ignored outside IDLE. When clear_req and ch_valid are high together in IDLE, the character is not accepted (ch_ready low) and the clear wins.
REQ-031 Back-to-back transfers SHALL be accepted one per cycle while in IDLE.

Reset
REQ-032 While rst is high: state IDLE; vm_we, vm_waddr, vm_wdata, cur_row, cur_col, top_row and busy all 0; ch_ready 0.
REQ-033 Reset asserted mid-clear SHALL abort the sequence immediately. Memory is not cleared by reset.

Structure
REQ-034 The state encoding, the default COLS/ROWS values and the ASCII constants (0x08, 0x0A, 0x0D, 0x20, 0x7E) SHALL live in a shared console package.
REQ-035 One sub-module SHALL be used: console_addr_gen, which computes phys_row*COLS+col and the mod-ROWS row addition.

Verification
REQ-036 Reset, then send 'A' (0x41) -> vm_we for one cycle with addr 0 and data 0x41; cur_col=1; ch_ready high throughout.
REQ-037 Send 70 printable characters from (0,0) -> addrs 0..69 written; afterwards cur_row=1, cur_col=0.
REQ-038 At cur_row=29, send 0x0A -> top_row=1, busy high for 70 cycles, 0x20 written to addrs 0..69, ch_ready low meanwhile.
REQ-039 At cur_col=0, send 0x08 -> no write, cursor unchanged. At cur_col=5, row 2, top 0, send 0x08 -> 0x20 written to addr 144, cur_col=4.
REQ-040 Pulse clear_req together with ch_valid -> char not accepted; 2100 writes of 0x20 to addrs 0..2099; then row, col and top all 0.
REQ-041 Assert rst during cycle 10 of FULL_CLR -> vm_we drops immediately; all outputs 0; ch_ready high after release.
